// File: rtl/pc_sequencer_pkg.sv
// pc_seq_pkg: shared FSM state encoding and retired-counter sizing for pc_sequencer.
package pc_seq_pkg;
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, STALL = 2'd2, HALT = 2'd3} state_e;
  localparam int RETIRED_W = 16;
  localparam logic [RETIRED_W-1:0] RETIRED_MAX = '1;
  function automatic logic [RETIRED_W-1:0] sat_inc(input logic [RETIRED_W-1:0] v);
    return (v == RETIRED_MAX) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/pc_sequencer_next_mux.sv
// pc_next_mux: priority select of the next PC; misaligned-target trapping under PC_MISALIGN_TRAP_EN.
module pc_next_mux
  import pc_seq_pkg::*;
#(
  parameter int              PC_W      = 8,
  parameter int              PC_STEP   = 4,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'(8'hF0)
) (
  input  state_e          state_i,
  input  logic            stall_i,
  input  logic            halt_req_i,
  input  logic            jump_i,
  input  logic [PC_W-1:0] jump_target_i,
  input  logic            branch_taken_i,
  input  logic [PC_W-1:0] branch_target_i,
  input  logic [PC_W-1:0] pc_q_i,
  output logic [PC_W-1:0] pc_d_o,
  output logic            misalign_o
);
  logic            active;
  logic            redirect;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] target_eff;
  assign active   = (state_i == RUN) && !halt_req_i && !stall_i;
  assign redirect = jump_i || branch_taken_i;
  assign target   = jump_i ? jump_target_i : branch_target_i;
`ifdef PC_MISALIGN_TRAP_EN
  assign misalign_o = active && redirect && (target[1:0] != 2'b00);
  assign target_eff = misalign_o ? TRAP_VEC : target;
`else
  assign misalign_o = 1'b0;
  assign target_eff = target;
`endif
  assign pc_d_o = (state_i == BOOT) ? RESET_VEC :
                  !active           ? pc_q_i :
                  redirect          ? target_eff :
                                      pc_q_i + PC_W'(PC_STEP);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller (boot, fetch, redirect, stall, halt) with retired counter.
// Optional misaligned-target trap enabled by PC_MISALIGN_TRAP_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W        = 8,
  parameter int              PC_STEP     = 4,
  parameter logic [PC_W-1:0] RESET_VEC   = '0,
  parameter int              BOOT_CYCLES = 2,
  parameter logic [PC_W-1:0] TRAP_VEC    = PC_W'(8'hF0)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 jump,
  input  logic [PC_W-1:0]      jump_target,
  input  logic                 branch_taken,
  input  logic [PC_W-1:0]      branch_target,
  input  logic                 halt_req,
  input  logic                 resume,
  input  logic [PC_W-1:0]      pc_q,
  output logic [PC_W-1:0]      pc_d,
  output logic                 pc_reset,
  output logic                 fetch_valid,
  output logic [1:0]           state,
  output logic [RETIRED_W-1:0] retired,
  output logic                 trap
);
  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  state_e                 state_q, state_d;
  logic [BW-1:0]          boot_cnt_q, boot_cnt_d;
  logic [RETIRED_W-1:0]   retired_q, retired_d;
  logic                   misalign;
  pc_next_mux #(
    .PC_W      (PC_W),
    .PC_STEP   (PC_STEP),
    .RESET_VEC (RESET_VEC),
    .TRAP_VEC  (TRAP_VEC)
  ) u_next_mux (
    .state_i         (state_q),
    .stall_i         (stall),
    .halt_req_i      (halt_req),
    .jump_i          (jump),
    .jump_target_i   (jump_target),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .pc_q_i          (pc_q),
    .pc_d_o          (pc_d),
    .misalign_o      (misalign)
  );
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    retired_d  = retired_q;
    case (state_q)
      BOOT: begin
        boot_cnt_d = boot_cnt_q + 1'b1;
        state_d    = (boot_cnt_q == BW'(BOOT_CYCLES - 1)) ? RUN : BOOT;
      end
      RUN: begin
        state_d   = halt_req ? HALT : stall ? STALL : RUN;
        retired_d = (halt_req || stall) ? retired_q : sat_inc(retired_q);
      end
      STALL:   state_d = halt_req ? HALT : stall ? STALL : RUN;
      HALT:    state_d = (resume && !halt_req) ? RUN : HALT;
      default: state_d = BOOT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      boot_cnt_q <= '0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      retired_q  <= retired_d;
    end
  end
`ifdef PC_MISALIGN_TRAP_EN
  logic trap_q;
  always_ff @(posedge clk) begin
    if (reset) trap_q <= 1'b0;
    else       trap_q <= misalign;
  end
  assign trap = trap_q;
`else
  // misalign is constant 0 in this build, so trap is tied low with no register
  assign trap = misalign;
`endif
  assign pc_reset    = reset;
  assign fetch_valid = (state_q == RUN) && !stall;
  assign state       = state_q;
  assign retired     = retired_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus randomized run against a behavioural model.
module tb_pc_sequencer;
  localparam int BOOT_CYCLES = 2;
  localparam int M_BOOT = 0, M_RUN = 1, M_STALL = 2, M_HALT = 3;
  logic        clk = 1'b0;
  logic        reset, stall, jump, branch_taken, halt_req, resume;
  logic [7:0]  jump_target, branch_target, pc_q, pc_d;
  logic        pc_reset, fetch_valid, trap;
  logic [1:0]  state;
  logic [15:0] retired;
  int n_cmp = 0, n_bad = 0;
  int m_state = M_BOOT, m_boot = 0, m_ret = 0;
  bit m_trap = 0, loop_pc = 1;
  always #5 clk = ~clk;
  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target), .halt_req(halt_req),
    .resume(resume), .pc_q(pc_q), .pc_d(pc_d), .pc_reset(pc_reset),
    .fetch_valid(fetch_valid), .state(state), .retired(retired), .trap(trap)
  );
  function automatic bit trap_on(input logic [7:0] t);
`ifdef PC_MISALIGN_TRAP_EN
    return t[1:0] != 2'b00;
`else
    return (t & 8'h00) != 8'h00;
`endif
  endfunction
  function automatic bit redirecting();
    return m_state == M_RUN && !halt_req && !stall && (jump || branch_taken);
  endfunction
  function automatic logic [7:0] exp_pc();
    logic [7:0] t;
    if (m_state == M_BOOT) return 8'h00;
    if (m_state != M_RUN || halt_req || stall) return pc_q;
    if (jump || branch_taken) begin
      t = jump ? jump_target : branch_target;
      return trap_on(t) ? 8'hF0 : t;
    end
    return 8'((int'(pc_q) + 4) % 256);
  endfunction
  task automatic tick();
    logic [7:0] nxt;
    bit nt;
    nxt = exp_pc();
    nt  = redirecting() && trap_on(jump ? jump_target : branch_target);
    if (reset) begin
      m_state = M_BOOT; m_boot = 0; m_ret = 0; m_trap = 0;
    end else begin
      m_trap = nt;
      case (m_state)
        M_BOOT: begin m_boot++; if (m_boot == BOOT_CYCLES) m_state = M_RUN; end
        M_RUN: if (halt_req) m_state = M_HALT; else if (stall) m_state = M_STALL;
               else if (m_ret < 65535) m_ret++;
        M_STALL: m_state = halt_req ? M_HALT : stall ? M_STALL : M_RUN;
        default: if (resume && !halt_req) m_state = M_RUN;
      endcase
    end
    @(posedge clk);
    @(negedge clk);
    if (loop_pc) pc_q = reset ? 8'h00 : nxt;
  endtask
  task automatic test_reset();
    reset = 1;
    tick();
    #1;
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    n_cmp++; if (retired !== 16'd0) begin n_bad++; $display("FAIL reset_retired got=%0d exp=0", retired); end
    n_cmp++; if (trap !== 1'b0) begin n_bad++; $display("FAIL reset_trap got=%b exp=0", trap); end
    n_cmp++; if (pc_reset !== 1'b1) begin n_bad++; $display("FAIL reset_pc_reset got=%b exp=1", pc_reset); end
    tick(); tick();
    reset = 0;
    #1;
    n_cmp++; if (pc_reset !== 1'b0) begin n_bad++; $display("FAIL release_pc_reset got=%b exp=0", pc_reset); end
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (pc_d !== 8'h00 || fetch_valid !== 1'b0) begin n_bad++; $display("FAIL boot_%0d pc_d=%h fv=%b exp 00/0", i, pc_d, fetch_valid); end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (pc_d !== 8'(4 * (i + 1)) || fetch_valid !== 1'b1) begin n_bad++; $display("FAIL seq_%0d pc_d=%h fv=%b exp %h/1", i, pc_d, fetch_valid, 8'(4 * (i + 1))); end
      tick();
    end
  endtask
  task automatic test_redirect();
    loop_pc = 0; pc_q = 8'h10;
    jump = 1; jump_target = 8'h40; branch_taken = 1; branch_target = 8'h20;
    #1;
    n_cmp++; if (pc_d !== 8'h40) begin n_bad++; $display("FAIL jump_priority got=%h exp=40", pc_d); end
    tick();
    jump = 0;
    #1;
    n_cmp++; if (pc_d !== 8'h20) begin n_bad++; $display("FAIL branch_only got=%h exp=20", pc_d); end
    tick();
    branch_taken = 0;
  endtask
  task automatic test_wrap();
    int r0;
    pc_q = 8'hFC; r0 = m_ret;
    #1;
    n_cmp++; if (pc_d !== 8'h00) begin n_bad++; $display("FAIL wrap_pc got=%h exp=00", pc_d); end
    tick();
    #1;
    n_cmp++; if (retired !== 16'(r0 + 1)) begin n_bad++; $display("FAIL wrap_retired got=%0d exp=%0d", retired, r0 + 1); end
  endtask
  task automatic test_stall();
    int r0;
    pc_q = 8'h08; r0 = m_ret; stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (pc_d !== 8'h08 || retired !== 16'(r0)) begin n_bad++; $display("FAIL stall_%0d pc_d=%h ret=%0d exp 08/%0d", i, pc_d, retired, r0); end
      if (i > 0) begin
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL stall_state_%0d got=%0d exp=2", i, state); end
      end
      tick();
    end
    stall = 0;
    #1;
    n_cmp++; if (state !== 2'd2 || pc_d !== 8'h08) begin n_bad++; $display("FAIL stall_release state=%0d pc_d=%h exp 2/08", state, pc_d); end
    tick();
    #1;
    n_cmp++; if (state !== 2'd1 || pc_d !== 8'h0C) begin n_bad++; $display("FAIL stall_resume state=%0d pc_d=%h exp 1/0C", state, pc_d); end
  endtask
  task automatic test_halt();
    halt_req = 1;
    tick();
    #1;
    n_cmp++; if (state !== 2'd3 || pc_d !== 8'h08) begin n_bad++; $display("FAIL halt_enter state=%0d pc_d=%h exp 3/08", state, pc_d); end
    resume = 1;
    tick();
    #1;
    n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL halt_both state=%0d exp=3", state); end
    halt_req = 0;
    tick();
    #1;
    n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL halt_resume state=%0d exp=1", state); end
    halt_req = 1; resume = 0;
    tick();
    halt_req = 0; reset = 1;
    tick();
    #1;
    n_cmp++; if (state !== 2'd0 || retired !== 16'd0) begin n_bad++; $display("FAIL halt_reset state=%0d ret=%0d exp 0/0", state, retired); end
    reset = 0;
    tick(); tick();
    #1;
    n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL reboot state=%0d exp=1", state); end
  endtask
  task automatic test_misalign();
    logic [7:0] e_pc;
    bit e_trap;
    int r0;
`ifdef PC_MISALIGN_TRAP_EN
    e_pc = 8'hF0; e_trap = 1;
`else
    e_pc = 8'h41; e_trap = 0;
`endif
    pc_q = 8'h20; jump = 1; jump_target = 8'h41; r0 = m_ret;
    #1;
    n_cmp++; if (pc_d !== e_pc) begin n_bad++; $display("FAIL misalign_pc got=%h exp=%h", pc_d, e_pc); end
    tick();
    jump = 0;
    #1;
    n_cmp++; if (trap !== e_trap || retired !== 16'(r0 + 1)) begin n_bad++; $display("FAIL misalign_trap trap=%b ret=%0d exp %b/%0d", trap, retired, e_trap, r0 + 1); end
    tick();
    #1;
    n_cmp++; if (trap !== 1'b0) begin n_bad++; $display("FAIL trap_pulse got=%b exp=0", trap); end
  endtask
  task automatic test_random();
    loop_pc = 1;
    for (int i = 0; i < 800; i++) begin
      reset        = $urandom_range(0, 99) < 2;
      stall        = $urandom_range(0, 99) < 15;
      halt_req     = $urandom_range(0, 99) < 8;
      resume       = $urandom_range(0, 99) < 30;
      jump         = $urandom_range(0, 99) < 20;
      branch_taken = $urandom_range(0, 99) < 20;
      jump_target   = 8'($urandom) & ($urandom_range(0, 1) ? 8'hFC : 8'hFF);
      branch_target = 8'($urandom) & ($urandom_range(0, 1) ? 8'hFC : 8'hFF);
      if ($urandom_range(0, 19) == 0) pc_q = 8'($urandom);
      #1;
      n_cmp++; if (pc_d !== exp_pc()) begin n_bad++; $display("FAIL rnd_pc_d cyc=%0d got=%h exp=%h", i, pc_d, exp_pc()); end
      n_cmp++; if (state !== 2'(m_state)) begin n_bad++; $display("FAIL rnd_state cyc=%0d got=%0d exp=%0d", i, state, m_state); end
      n_cmp++; if (fetch_valid !== (m_state == M_RUN && !stall)) begin n_bad++; $display("FAIL rnd_fetch_valid cyc=%0d got=%b", i, fetch_valid); end
      n_cmp++; if (retired !== 16'(m_ret)) begin n_bad++; $display("FAIL rnd_retired cyc=%0d got=%0d exp=%0d", i, retired, m_ret); end
      n_cmp++; if (trap !== m_trap) begin n_bad++; $display("FAIL rnd_trap cyc=%0d got=%b exp=%b", i, trap, m_trap); end
      n_cmp++; if (pc_reset !== reset) begin n_bad++; $display("FAIL rnd_pc_reset cyc=%0d got=%b exp=%b", i, pc_reset, reset); end
      tick();
    end
  endtask
  initial begin
    reset = 1; stall = 0; jump = 0; branch_taken = 0; halt_req = 0; resume = 0;
    jump_target = 8'h00; branch_target = 8'h00; pc_q = 8'h00;
    @(negedge clk);
    test_reset();
    test_redirect();
    test_wrap();
    test_stall();
    test_halt();
    test_misalign();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
